// File: rtl/hamming_precompute.sv
// Registered Hamming(21,16) encoder with fixed XOR parity masks.
// Codeword position i (1..21) lives in y[i-1]; parity sits at positions 1,2,4,8,16.
module hamming_precompute (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] m,
   output logic        out_valid,
   output logic [20:0] y,
   output logic [4:0]  parity
);

   // Parity coverage masks over the data-only codeword (bit index = position-1).
   localparam logic [20:0] MASK_P1  = 21'h155554;
   localparam logic [20:0] MASK_P2  = 21'h066664;
   localparam logic [20:0] MASK_P4  = 21'h187870;
   localparam logic [20:0] MASK_P8  = 21'h007F00;
   localparam logic [20:0] MASK_P16 = 21'h1F0000;

   logic [20:0] data_pos;
   logic [4:0]  par_calc;
   logic [20:0] code_calc;

   logic        out_valid_d, out_valid_q;
   logic [20:0] y_d, y_q;
   logic [4:0]  parity_d, parity_q;

   // Place message bits at the non-power-of-two positions and derive even parity.
   always_comb begin
      data_pos       = '0;
      data_pos[2]    = m[0];
      data_pos[4]    = m[1];
      data_pos[5]    = m[2];
      data_pos[6]    = m[3];
      data_pos[8]    = m[4];
      data_pos[9]    = m[5];
      data_pos[10]   = m[6];
      data_pos[11]   = m[7];
      data_pos[12]   = m[8];
      data_pos[13]   = m[9];
      data_pos[14]   = m[10];
      data_pos[16]   = m[11];
      data_pos[17]   = m[12];
      data_pos[18]   = m[13];
      data_pos[19]   = m[14];
      data_pos[20]   = m[15];

      par_calc[4]    = ^(data_pos & MASK_P16);
      par_calc[3]    = ^(data_pos & MASK_P8);
      par_calc[2]    = ^(data_pos & MASK_P4);
      par_calc[1]    = ^(data_pos & MASK_P2);
      par_calc[0]    = ^(data_pos & MASK_P1);

      code_calc      = data_pos;
      code_calc[0]   = par_calc[0];
      code_calc[1]   = par_calc[1];
      code_calc[3]   = par_calc[2];
      code_calc[7]   = par_calc[3];
      code_calc[15]  = par_calc[4];
   end

   // Next-state: capture on in_valid, otherwise hold the codeword and drop valid.
   always_comb begin
      out_valid_d = in_valid;
      y_d         = y_q;
      parity_d    = parity_q;
      if (in_valid) begin
         y_d      = code_calc;
         parity_d = par_calc;
      end
   end

   // Single output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         parity_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         parity_q    <= parity_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign parity    = parity_q;

endmodule

// File: tb/tb_hamming_precompute.sv
module tb_hamming_precompute;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] m;
   logic        out_valid;
   logic [20:0] y;
   logic [4:0]  parity;

   int vectors = 0;
   int miscompares = 0;

   // Hand-computed codewords for a single one at m[k].
   logic [20:0] walk_y [16];

   hamming_precompute dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .m         (m),
      .out_valid (out_valid),
      .y         (y),
      .parity    (parity)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Encoder is linear: the codeword is the XOR of the single-bit codewords.
   function automatic logic [20:0] enc(input logic [15:0] msg);
      logic [20:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) if (msg[k]) r ^= walk_y[k];
      return r;
   endfunction

   function automatic logic [4:0] par_of(input logic [20:0] cw);
      return {cw[15], cw[7], cw[3], cw[1], cw[0]};
   endfunction

   function automatic logic [4:0] syndrome(input logic [20:0] cw);
      logic [4:0] s;
      s = '0;
      for (int i = 0; i < 21; i++) if (cw[i]) s ^= 5'(i + 1);
      return s;
   endfunction

   function automatic logic [15:0] extract(input logic [20:0] cw);
      return {cw[20], cw[19], cw[18], cw[17], cw[16], cw[14], cw[13], cw[12],
              cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
   endfunction

   task automatic apply(input logic [15:0] msg);
      @(posedge clk); #1;
      m = msg; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] cur, prev;
      logic [15:0] one;

      walk_y[0]  = 21'h000007; walk_y[1]  = 21'h000019;
      walk_y[2]  = 21'h00002A; walk_y[3]  = 21'h00004B;
      walk_y[4]  = 21'h000181; walk_y[5]  = 21'h000282;
      walk_y[6]  = 21'h000483; walk_y[7]  = 21'h000888;
      walk_y[8]  = 21'h001089; walk_y[9]  = 21'h00208A;
      walk_y[10] = 21'h00408B; walk_y[11] = 21'h018001;
      walk_y[12] = 21'h028002; walk_y[13] = 21'h048003;
      walk_y[14] = 21'h088008; walk_y[15] = 21'h108009;

      // Reset held with valid input present.
      rst_n = 1'b0; in_valid = 1'b1; m = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_y", 32'(y), 32'h0);
      check("rst_parity", 32'(parity), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_y", 32'(y), 32'h1FFFFE);
      // Asynchronous clear mid-cycle.
      #2 rst_n = 1'b0;
      #1;
      check("async_y", 32'(y), 32'h0);
      check("async_parity", 32'(parity), 32'h0);
      check("async_valid", 32'(out_valid), 32'h0);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Reference vector.
      apply(16'h578D);
      check("ref_y", 32'(y), 32'h0A786C);
      check("ref_parity", 32'(parity), 32'h04);
      check("ref_valid", 32'(out_valid), 32'h1);
      @(posedge clk); #1;
      check("ref_hold_valid", 32'(out_valid), 32'h0);
      check("ref_hold_y", 32'(y), 32'h0A786C);
      check("ref_hold_parity", 32'(parity), 32'h04);

      // Extremes.
      apply(16'h0000);
      check("zero_y", 32'(y), 32'h0);
      check("zero_parity", 32'(parity), 32'h0);
      apply(16'hFFFF);
      check("ones_y", 32'(y), 32'h1FFFFE);
      check("ones_parity", 32'(parity), 32'h1E);

      // Single-bit walk.
      for (int k = 0; k < 16; k++) begin
         one = 16'h0001 << k;
         apply(one);
         check($sformatf("walk%0d_y", k), 32'(y), 32'(walk_y[k]));
         check($sformatf("walk%0d_parity", k), 32'(parity), 32'(par_of(walk_y[k])));
         check($sformatf("walk%0d_valid", k), 32'(out_valid), 32'h1);
      end

      // Continuous stream.
      @(posedge clk); #1;
      cur = 16'($urandom); m = cur; in_valid = 1'b1;
      for (int i = 1; i < 1000; i++) begin
         @(posedge clk); #1;
         prev = cur;
         cur = 16'($urandom); m = cur;
         check("stream_valid", 32'(out_valid), 32'h1);
         check("stream_y", 32'(y), 32'(enc(prev)));
         check("stream_parity", 32'(parity), 32'(par_of(enc(prev))));
         check("stream_syndrome", 32'(syndrome(y)), 32'h0);
         check("stream_data", 32'(extract(y)), 32'(prev));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stream_last_y", 32'(y), 32'(enc(cur)));
      check("stream_last_syndrome", 32'(syndrome(y)), 32'h0);

      // Reset between two valid words.
      m = 16'h1234; in_valid = 1'b1;
      @(posedge clk); #1;
      check("mid_a_y", 32'(y), 32'(enc(16'h1234)));
      m = 16'hBEEF;
      #2 rst_n = 1'b0;
      #1;
      check("mid_clr_y", 32'(y), 32'h0);
      check("mid_clr_valid", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
      check("mid_held_y", 32'(y), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_resume_y", 32'(y), 32'(enc(16'hBEEF)));
      check("mid_resume_parity", 32'(parity), 32'(par_of(enc(16'hBEEF))));
      check("mid_resume_valid", 32'(out_valid), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
